// File: rtl/audio_pkg.sv
// Shared audio definitions: default sample width and silence encoding helper.
package audio_pkg;

   localparam int AUDIO_DW = 16;

   // Two's complement silence is zero; offset-binary silence is the mid-scale code.
   function automatic logic [31:0] silence_val(input logic signed_sample, input int width);
      silence_val = signed_sample ? 32'd0 : (32'd1 << (width - 1));
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, combinational head read, registered level; pushes while full are dropped.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk_sys,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_dat,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_dat,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_level;
   logic             w_push;
   logic             w_pop;

   assign full    = (r_level == (PTR_W+1)'(DEPTH));
   assign empty   = (r_level == '0);
   assign level   = r_level;
   assign pop_dat = r_mem[r_rd_ptr];
   assign w_push  = push & ~full;
   assign w_pop   = pop & ~empty;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage is not reset; the pointers alone define validity.
   always_ff @(posedge clk_sys) begin
      if (w_push) r_mem[r_wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/i2s_sample_sched.sv
// Buffers stereo pairs and presents one per I2S frame, one cycle after the lrclk falling edge.
// in_ready drops only when the FIFO is full; a pop in the same cycle does not free a slot early.
module i2s_sample_sched #(
   parameter int AUDIO_DW       = audio_pkg::AUDIO_DW,
   parameter int FIFO_DEPTH     = 4,
   parameter bit UNDERFLOW_ZERO = 1'b0
) (
   input  logic                          clk_sys,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [AUDIO_DW-1:0]           in_left,
   input  logic [AUDIO_DW-1:0]           in_right,
   input  logic                          signed_sample,
   input  logic                          mute,
   input  logic                          lrclk,
   output logic [AUDIO_DW-1:0]           left_chan,
   output logic [AUDIO_DW-1:0]           right_chan,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          underflow,
   output logic [15:0]                   underflow_cnt
);

   import audio_pkg::*;

   logic [AUDIO_DW-1:0]   r_left_chan;
   logic [AUDIO_DW-1:0]   r_right_chan;
   logic                  r_lrclk_q;
   logic [15:0]           r_underflow_cnt;
   logic [AUDIO_DW-1:0]   w_silence;
   logic                  w_frame_stb;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic [2*AUDIO_DW-1:0] w_head;

   assign w_silence   = AUDIO_DW'(silence_val(signed_sample, AUDIO_DW));
   assign w_frame_stb = r_lrclk_q & ~lrclk;
   assign in_ready    = ~w_full;
   assign w_push      = in_valid & ~w_full;
   assign w_pop       = w_frame_stb & ~w_empty;
   assign underflow   = w_frame_stb & w_empty;

   assign left_chan     = r_left_chan;
   assign right_chan    = r_right_chan;
   assign underflow_cnt = r_underflow_cnt;

   sync_fifo #(
      .WIDTH (2*AUDIO_DW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .push     (w_push),
      .push_dat ({in_left, in_right}),
      .pop      (w_pop),
      .pop_dat  (w_head),
      .full     (w_full),
      .empty    (w_empty),
      .level    (fifo_level)
   );

   // lrclk_q resets high so a low lrclk at reset release reads as a frame start, like the serializer.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_lrclk_q <= 1'b1;
      end else begin
         r_lrclk_q <= lrclk;
      end
   end

   // Outputs only move on the strobe so the serializer sees a pair stable for the whole frame.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_left_chan  <= w_silence;
         r_right_chan <= w_silence;
      end else if (w_frame_stb) begin
         if (!w_empty && !mute) begin
            r_left_chan  <= w_head[2*AUDIO_DW-1:AUDIO_DW];
            r_right_chan <= w_head[AUDIO_DW-1:0];
         end else if (!w_empty || UNDERFLOW_ZERO || mute) begin
            r_left_chan  <= w_silence;
            r_right_chan <= w_silence;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_underflow_cnt <= '0;
      end else if (underflow && (r_underflow_cnt != 16'hFFFF)) begin
         r_underflow_cnt <= r_underflow_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_i2s_sample_sched.sv
// Directed bench for i2s_sample_sched: inputs change and outputs are sampled after the falling clock edge.
module tb_i2s_sample_sched;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_left;
   logic [15:0] in_right;
   logic        signed_sample;
   logic        mute;
   logic        lrclk;
   logic [15:0] left_chan;
   logic [15:0] right_chan;
   logic [2:0]  fifo_level;
   logic        underflow;
   logic [15:0] underflow_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk_sys = ~clk_sys;

   i2s_sample_sched #(
      .AUDIO_DW       (16),
      .FIFO_DEPTH     (4),
      .UNDERFLOW_ZERO (1'b0)
   ) dut (
      .clk_sys       (clk_sys),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_left       (in_left),
      .in_right      (in_right),
      .signed_sample (signed_sample),
      .mute          (mute),
      .lrclk         (lrclk),
      .left_chan     (left_chan),
      .right_chan    (right_chan),
      .fifo_level    (fifo_level),
      .underflow     (underflow),
      .underflow_cnt (underflow_cnt)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk_sys);
   endtask

   task automatic push(input logic [15:0] l, input logic [15:0] r);
      in_valid = 1'b1;
      in_left  = l;
      in_right = r;
      cyc();
      in_valid = 1'b0;
   endtask

   // One lrclk fall followed by the return high; outputs are settled on return.
   task automatic strobe();
      lrclk = 1'b0;
      cyc();
      lrclk = 1'b1;
      cyc();
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_left = '0; in_right = '0;
      signed_sample = 1'b0; mute = 1'b0; lrclk = 1'b1;
      cyc(); cyc(); cyc();
      reset = 1'b0; #1;
      chk("rst_left_offset",  left_chan,  16'h8000);
      chk("rst_right_offset", right_chan, 16'h8000);
      chk("rst_in_ready",     16'(in_ready),   16'h0001);
      chk("rst_level",        16'(fifo_level), 16'h0000);
      chk("rst_underflow",    16'(underflow),  16'h0000);
      chk("rst_cnt",          underflow_cnt,   16'h0000);

      signed_sample = 1'b1; reset = 1'b1;
      cyc(); cyc();
      reset = 1'b0; #1;
      chk("rst_left_signed",  left_chan,  16'h0000);
      chk("rst_right_signed", right_chan, 16'h0000);

      // Two pairs out in order, then an underflow that holds the last pair.
      cyc();
      push(16'h1111, 16'h2222);
      push(16'h3333, 16'h4444);
      chk("t2_level2", 16'(fifo_level), 16'h0002);
      strobe();
      chk("t2_left1",  left_chan,  16'h1111);
      chk("t2_right1", right_chan, 16'h2222);
      chk("t2_level1", 16'(fifo_level), 16'h0001);
      strobe();
      chk("t2_left2",  left_chan,  16'h3333);
      chk("t2_right2", right_chan, 16'h4444);
      chk("t2_level0", 16'(fifo_level), 16'h0000);
      lrclk = 1'b0; #1;
      chk("t2_uf_pulse", 16'(underflow), 16'h0001);
      cyc();
      chk("t2_uf_clear", 16'(underflow), 16'h0000);
      chk("t2_uf_cnt",   underflow_cnt,  16'h0001);
      lrclk = 1'b1; cyc();
      chk("t2_hold_left",  left_chan,  16'h3333);
      chk("t2_hold_right", right_chan, 16'h4444);

      // Fill to full with in_valid held; pop while full must not admit a push that cycle.
      in_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         in_left  = 16'hA000 + 16'(i);
         in_right = 16'hB000 + 16'(i);
         cyc();
      end
      #1;
      chk("t3_full_ready", 16'(in_ready),   16'h0000);
      chk("t3_full_level", 16'(fifo_level), 16'h0004);
      in_left = 16'hA005; in_right = 16'hB005; lrclk = 1'b0; #1;
      chk("t3_stb_ready", 16'(in_ready), 16'h0000);
      cyc();
      chk("t3_after_pop_level", 16'(fifo_level), 16'h0003);
      chk("t3_after_pop_left",  left_chan,  16'hA001);
      lrclk = 1'b1;
      cyc();
      in_valid = 1'b0;
      chk("t3_refill_level", 16'(fifo_level), 16'h0004);
      strobe(); chk("t3_order2", left_chan, 16'hA002);
      strobe(); chk("t3_order3", left_chan, 16'hA003);
      strobe(); chk("t3_order4", left_chan, 16'hA004);
      strobe();
      chk("t3_order5_l", left_chan,  16'hA005);
      chk("t3_order5_r", right_chan, 16'hB005);
      chk("t3_drained",  16'(fifo_level), 16'h0000);

      // Push landing on the strobe of an empty FIFO is still an underflow.
      in_valid = 1'b1; in_left = 16'hC001; in_right = 16'hC002; lrclk = 1'b0; #1;
      chk("t4_uf_pulse", 16'(underflow), 16'h0001);
      chk("t4_ready",    16'(in_ready),  16'h0001);
      cyc();
      in_valid = 1'b0;
      chk("t4_level",     16'(fifo_level), 16'h0001);
      chk("t4_hold_left", left_chan,       16'hA005);
      chk("t4_cnt",       underflow_cnt,   16'h0002);
      lrclk = 1'b1; cyc();
      strobe();
      chk("t4_left",  left_chan,  16'hC001);
      chk("t4_right", right_chan, 16'hC002);

      // Mute pops but outputs offset-binary silence.
      signed_sample = 1'b0;
      push(16'hD001, 16'hD002);
      push(16'hE001, 16'hE002);
      mute = 1'b1;
      strobe();
      chk("t5_mute1_left",  left_chan,  16'h8000);
      chk("t5_mute1_right", right_chan, 16'h8000);
      chk("t5_mute1_level", 16'(fifo_level), 16'h0001);
      strobe();
      chk("t5_mute2_left",  left_chan,  16'h8000);
      chk("t5_mute2_level", 16'(fifo_level), 16'h0000);
      mute = 1'b0;
      push(16'hF001, 16'hF002);
      strobe();
      chk("t5_unmute_left",  left_chan,  16'hF001);
      chk("t5_unmute_right", right_chan, 16'hF002);
      mute = 1'b1; cyc(); cyc();
      chk("t5_mute_midframe", left_chan, 16'hF001);
      mute = 1'b0;

      // Underflow counting, then saturation from a preloaded count.
      for (int i = 0; i < 100; i++) strobe();
      chk("t6_cnt102",   underflow_cnt, 16'h0066);
      chk("t6_uf_hold",  left_chan,     16'hF001);
      force dut.r_underflow_cnt = 16'hFFFC;
      cyc();
      release dut.r_underflow_cnt;
      for (int i = 0; i < 5; i++) strobe();
      chk("t6_cnt_sat", underflow_cnt, 16'hFFFF);

      push(16'h1001, 16'h1002);
      push(16'h2001, 16'h2002);
      push(16'h3001, 16'h3002);
      chk("t6_pre_rst_level", 16'(fifo_level), 16'h0003);
      reset = 1'b1; cyc(); reset = 1'b0; #1;
      chk("t6_rst_level", 16'(fifo_level), 16'h0000);
      chk("t6_rst_left",  left_chan,       16'h8000);
      chk("t6_rst_right", right_chan,      16'h8000);
      chk("t6_rst_cnt",   underflow_cnt,   16'h0000);
      lrclk = 1'b0; #1;
      chk("t6_rst_uf", 16'(underflow), 16'h0001);
      cyc(); lrclk = 1'b1; cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
